fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared defaults, FSM state type and counter width for fifo_wr_arbiter
package fifo_arb_pkg;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_DW        = 8;
    localparam int DEF_MAX_BURST = 4;
    localparam int CNT_W         = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker scanning from last+1 upward with wrap
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int j;

    // Walk from farthest to nearest so the nearest requester after last is the final assignment.
    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(last) + k) % NREQ;
            if (req[j]) begin
                idx = IW'(j);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for a shared FIFO write port
// Optional per-requester grant counters enabled by FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    input  logic                 fifo_full,
    output logic                 fifo_wr,
    output logic [DW-1:0]        fifo_data_in
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NREQ*CNT_W-1:0] gnt_cnt
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q, last_d;
    logic [3:0]    bcnt_q, bcnt_d;

    logic [IW-1:0] pick_idx;
    logic          pick_any;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req  (req),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        bcnt_d       = bcnt_q;
        fifo_wr      = 1'b0;
        gnt          = '0;
        fifo_data_in = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BURST;
                    owner_d = pick_idx;
                    bcnt_d  = 4'd0;
                end
            end
            BURST: begin
                fifo_data_in = req_data[owner_q*DW +: DW];
                fifo_wr      = req[owner_q] && !fifo_full;
                if (fifo_wr) begin
                    gnt = NREQ'(1) << owner_q;
                end
                // A full FIFO with the owner still requesting holds everything in place.
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end else if (fifo_wr) begin
                    bcnt_d = bcnt_q + 4'd1;
                    if (bcnt_q == 4'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
            bcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NREQ];
    logic [CNT_W-1:0] cnt_d [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (gnt[i] && cnt_q[i] != {CNT_W{1'b1}}) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        gnt_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule
